// File: rtl/addsub_pipe.sv
// Pipelined adder-subtractor: the carry chain is cut into STAGES registered slices,
// with a global valid/ready stall and a selectable signed-overflow policy on the result.
module addsub_pipe #(
    parameter int WIDTH    = 16,
    parameter int STAGES   = 4,
    parameter int OVF_MODE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SL   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    logic stall;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int UPW = WIDTH - k * SL;  // operand bits not yet consumed

        logic [UPW-1:0]      a_in, b_in;
        logic                c_in, v_in;
        logic [SL:0]         slice_sum;
        logic [(k+1)*SL-1:0] s_d, s_q;
        logic                c_q, v_q;

        if (k == 0) begin : g_head
            assign a_in = a;
            assign b_in = sub ? ~b : b;
            assign c_in = sub ? 1'b1 : cin;
            assign v_in = in_valid;
            assign s_d  = slice_sum[SL-1:0];
        end else begin : g_link
            assign a_in = g_stage[k-1].g_fwd.a_q;
            assign b_in = g_stage[k-1].g_fwd.b_q;
            assign c_in = g_stage[k-1].c_q;
            assign v_in = g_stage[k-1].v_q;
            assign s_d  = {slice_sum[SL-1:0], g_stage[k-1].s_q};
        end

        assign slice_sum = {1'b0, a_in[SL-1:0]} + {1'b0, b_in[SL-1:0]} + {{SL{1'b0}}, c_in};

        // NOTE: data registers are reset too, so sum/cout/ovf read 0 straight out of reset.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s_q <= '0;
                c_q <= 1'b0;
                v_q <= 1'b0;
            end else if (!stall) begin
                s_q <= s_d;
                c_q <= slice_sum[SL];
                v_q <= v_in;
            end
        end

        if (k < LAST) begin : g_fwd
            logic [UPW-SL-1:0] a_q, b_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (!stall) begin
                    a_q <= a_in[UPW-1:SL];
                    b_q <= b_in[UPW-1:SL];
                end
            end
        end else begin : g_msb
            // Carry into the MSB is recovered from the MSB sum bit: c = a ^ b' ^ s.
            logic ovf_d, ovf_q;

            assign ovf_d = a_in[SL-1] ^ b_in[SL-1] ^ slice_sum[SL-1] ^ slice_sum[SL];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (!stall) begin
                    ovf_q <= ovf_d;
                end
            end
        end
    end

    assign out_valid = g_stage[LAST].v_q;
    assign stall     = out_valid && !out_ready;
    assign in_ready  = !stall;
    assign cout      = g_stage[LAST].c_q;
    assign ovf       = g_stage[LAST].g_msb.ovf_q;

    always_comb begin
        sum = g_stage[LAST].s_q;
        if (ovf && OVF_MODE == 1) begin
            sum = '0;
        end else if (ovf && OVF_MODE == 2) begin
            // A raw MSB of 1 after overflow means the true result was positive.
            sum = g_stage[LAST].s_q[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                             : {1'b1, {(WIDTH-1){1'b0}}};
        end
    end

endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench for addsub_pipe: three instances (wrap/zero/saturate) share stimulus;
// a queue of arithmetic-model results is checked against every presented output beat.
module tb_addsub_pipe;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst, in_valid, sub, cin, out_ready;
    logic [W-1:0] a, b;

    logic         in_ready, out_valid, cout, ovf;
    logic [W-1:0] sum;
    logic         in_ready0, out_valid0, cout0, ovf0;
    logic [W-1:0] sum0;
    logic         in_ready2, out_valid2, cout2, ovf2;
    logic [W-1:0] sum2;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [W-1:0] s0, s1, s2;
        logic         c, o;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    addsub_pipe #(.WIDTH(W), .STAGES(4), .OVF_MODE(1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .sub(sub), .cin(cin), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .cout(cout), .ovf(ovf)
    );

    addsub_pipe #(.WIDTH(W), .STAGES(4), .OVF_MODE(0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .a(a), .b(b),
        .sub(sub), .cin(cin), .out_valid(out_valid0), .out_ready(out_ready), .sum(sum0),
        .cout(cout0), .ovf(ovf0)
    );

    addsub_pipe #(.WIDTH(W), .STAGES(4), .OVF_MODE(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .a(a), .b(b),
        .sub(sub), .cin(cin), .out_valid(out_valid2), .out_ready(out_ready), .sum(sum2),
        .cout(cout2), .ovf(ovf2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic, signed range test for overflow.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic s, input logic ci);
        exp_t e;
        int   sx, sy, sres, ures;
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (s) begin
            sres = sx - sy;
            ures = int'(x) - int'(y);
            e.c  = (x >= y);
        end else begin
            sres = sx + sy + int'(ci);
            ures = int'(x) + int'(y) + int'(ci);
            e.c  = (ures > 65535);
        end
        e.s0 = ures[W-1:0];
        e.o  = (sres > 32767) || (sres < -32768);
        e.s1 = e.o ? '0 : e.s0;
        e.s2 = e.o ? ((sres > 0) ? 16'h7FFF : 16'h8000) : e.s0;
        return e;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'h7FFF;
            2:       return 16'h8000;
            3:       return 16'hFFFF;
            default: return W'($urandom);
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) q.delete();
        else if (in_valid && in_ready) q.push_back(model(a, b, sub, cin));
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("in_ready rule", in_ready, !(out_valid && !out_ready));
            check("mode0 valid", out_valid0, out_valid);
            check("mode2 valid", out_valid2, out_valid);
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("spurious out_valid", 1, 0);
                end else begin
                    check("sum mode1", sum, q[0].s1);
                    check("sum mode0", sum0, q[0].s0);
                    check("sum mode2", sum2, q[0].s2);
                    check("cout", cout, q[0].c);
                    check("ovf", ovf, q[0].o);
                    check("cout/ovf mode0", {cout0, ovf0}, {q[0].c, q[0].o});
                    check("cout/ovf mode2", {cout2, ovf2}, {q[0].c, q[0].o});
                    if (out_ready) void'(q.pop_front());
                end
            end
        end
    end

    task automatic run_one(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts,
                           input logic tc, input logic [W-1:0] e0, input logic [W-1:0] e1,
                           input logic [W-1:0] e2, input logic ec, input logic eo,
                           input string nm);
        int cnt;
        in_valid  = 1'b1;
        a         = ta;
        b         = tb_v;
        sub       = ts;
        cin       = tc;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cnt      = 1;
        while (!out_valid && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        check({nm, " latency"}, cnt, 4);
        check({nm, " sum1"}, sum, e1);
        check({nm, " sum0"}, sum0, e0);
        check({nm, " sum2"}, sum2, e2);
        check({nm, " cout"}, cout, ec);
        check({nm, " ovf"}, ovf, eo);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [W-1:0] held;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; cin = 1'b0; out_ready = 1'b1;
        #12;
        check("reset out_valid", out_valid, 0);
        check("reset sum", sum, 0);
        check("reset cout", cout, 0);
        check("reset ovf", ovf, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("in_ready after reset", in_ready, 1);

        run_one(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 16'h0000, 16'h7FFF, 1'b0, 1'b1, "pos_ovf");
        run_one(16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 16'h0000, 16'h8000, 1'b1, 1'b1, "neg_ovf");
        run_one(16'h0005, 16'h0003, 1'b1, 1'b0, 16'h0002, 16'h0002, 16'h0002, 1'b1, 1'b0, "sub_small");
        run_one(16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 16'h1000, 16'h1000, 1'b0, 1'b0, "seg_carry");
        run_one(16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, "cout_wrap");

        // Back-to-back: beat i (1..8) must show on the i-th consecutive cycle from cycle 4.
        for (int t = 0; t < 16; t++) begin
            in_valid = (t < 8);
            a = W'(t + 1);
            b = W'(t + 1);
            sub = 1'b0;
            cin = 1'b0;
            @(posedge clk); #1;
            if (t >= 3 && t < 11) begin
                check("b2b valid", out_valid, 1);
                check("b2b sum", sum, 2 * (t - 2));
            end else begin
                check("b2b idle", out_valid, 0);
            end
        end
        in_valid = 1'b0;

        // Backpressure: five stalled cycles with the source still pushing.
        for (int t = 0; t < 12; t++) begin
            in_valid  = 1'b1;
            a         = pick();
            b         = pick();
            sub       = 1'($urandom);
            cin       = 1'($urandom);
            out_ready = !(t >= 4 && t < 9);
            #1;
            if (t >= 4 && t < 9) begin
                check("bp in_ready", in_ready, 0);
                check("bp out_valid", out_valid, 1);
                if (t == 4) held = sum;
                else check("bp sum stable", sum, held);
            end
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("bp queue drained", q.size(), 0);

        // Reset mid-flight: three beats in the pipe are discarded.
        for (int t = 0; t < 3; t++) begin
            in_valid = 1'b1;
            a = W'(16'h0100 * (t + 1));
            b = 16'h0001;
            sub = 1'b0;
            cin = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        check("midrst out_valid", out_valid, 0);
        check("midrst sum", sum, 0);
        check("midrst cout/ovf", {cout, ovf}, 2'b00);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        run_one(16'h1234, 16'h1111, 1'b0, 1'b1, 16'h2346, 16'h2346, 16'h2346, 1'b0, 1'b0, "post_rst");

        // Randomised traffic with random backpressure.
        for (int t = 0; t < 400; t++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            a         = pick();
            b         = pick();
            sub       = 1'($urandom);
            cin       = 1'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("random queue drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
